// File: rtl/scope_pkg.sv
// scope_pkg: shared state encoding for the scope capture block
package scope_pkg;
  typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, READ} state_t;
endpackage

// File: rtl/capture_ram.sv
// capture_ram: single write port, synchronous read port sample buffer
module capture_ram #(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic [A_WIDTH-1:0] waddr,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic [A_WIDTH-1:0] raddr,
  output logic [D_WIDTH-1:0] q
);
  logic [D_WIDTH-1:0] mem [2**A_WIDTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    q <= mem[raddr];
  end
endmodule

// File: rtl/scope_capture.sv
// scope_capture: pre/post-trigger capture buffer with valid/ready oldest-first readout
module scope_capture
  import scope_pkg::*;
#(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [D_WIDTH-1:0] din,
  input  logic               arm,
  input  logic               abort,
  input  logic [D_WIDTH-1:0] level,
  input  logic [A_WIDTH-1:0] pre,
  output logic [D_WIDTH-1:0] rd_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic               rd_last,
  output logic               triggered,
  output logic               busy
);
  localparam logic [A_WIDTH:0]   DEPTH_C = {1'b1, {A_WIDTH{1'b0}}};
  localparam logic [A_WIDTH:0]   C1 = {{A_WIDTH{1'b0}}, 1'b1};
  localparam logic [A_WIDTH-1:0] A1 = {{(A_WIDTH-1){1'b0}}, 1'b1};
  state_t state;
  logic [A_WIDTH-1:0] wptr, raddr, pre_l;
  logic [A_WIDTH:0] pcnt, post_cnt, bcnt, post_len;
  logic [D_WIDTH-1:0] prev, q;
  logic prev_valid, we, trig;
  assign we = en && !abort && (state == PRE || state == WAIT || state == POST);
  assign trig = en && prev_valid && (prev < level) && (din >= level);
  assign post_len = DEPTH_C - {1'b0, pre_l};
  // RAM output has no reset, so gate it to keep rd_data at 0 whenever idle
  assign rd_data = rd_valid ? q : '0;
  capture_ram #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) u_ram (
    .clk(clk), .we(we), .waddr(wptr), .wdata(din), .raddr(raddr), .q(q)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wptr <= '0;
      raddr <= '0;
      pre_l <= '0;
      pcnt <= '0;
      post_cnt <= '0;
      bcnt <= '0;
      prev <= '0;
      prev_valid <= 1'b0;
      rd_valid <= 1'b0;
      rd_last <= 1'b0;
      triggered <= 1'b0;
      busy <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      wptr <= '0;
      pcnt <= '0;
      post_cnt <= '0;
      bcnt <= '0;
      prev_valid <= 1'b0;
      rd_valid <= 1'b0;
      rd_last <= 1'b0;
      triggered <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (arm) begin
          pre_l <= pre;
          wptr <= '0;
          pcnt <= '0;
          prev_valid <= 1'b0;
          busy <= 1'b1;
          state <= (pre == '0) ? WAIT : PRE;
        end
        PRE: if (en) begin
          wptr <= wptr + A1;
          pcnt <= pcnt + C1;
          prev <= din;
          prev_valid <= 1'b1;
          if (pcnt + C1 == {1'b0, pre_l}) state <= WAIT;
        end
        WAIT: if (en) begin
          wptr <= wptr + A1;
          prev <= din;
          prev_valid <= 1'b1;
          if (trig) begin
            triggered <= 1'b1;
            raddr <= wptr - pre_l;
            post_cnt <= C1;
            bcnt <= '0;
            state <= (post_len == C1) ? READ : POST;
          end
        end
        POST: if (en) begin
          wptr <= wptr + A1;
          post_cnt <= post_cnt + C1;
          if (post_cnt + C1 == post_len) state <= READ;
        end
        READ: if (!rd_valid) begin
          rd_valid <= 1'b1;
          rd_last <= (bcnt == DEPTH_C - C1);
        end else if (rd_ready) begin
          rd_valid <= 1'b0;
          rd_last <= 1'b0;
          raddr <= raddr + A1;
          bcnt <= bcnt + C1;
          if (rd_last) begin
            state <= IDLE;
            triggered <= 1'b0;
            busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scope_capture.sv
// tb_scope_capture: directed capture scenarios with a queue-based readout scoreboard
module tb_scope_capture;
  logic clk = 0, rst_n = 0, en = 0, arm = 0, abort = 0, rd_ready = 0;
  logic [7:0] din = 0, level = 0, rd_data;
  logic [3:0] pre = 0;
  logic rd_valid, rd_last, triggered, busy;
  int checks = 0, fails = 0, beats = 0;
  logic [8:0] exp_q[$];
  logic [8:0] e, held;
  logic hs_d = 0, hold = 0;

  always #5 clk = ~clk;

  scope_capture #(.D_WIDTH(8), .A_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .arm(arm), .abort(abort),
    .level(level), .pre(pre), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_last(rd_last), .triggered(triggered), .busy(busy)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // monitor: pops the scoreboard on every handshake, checks hold and gap rules
  initial forever begin
    @(negedge clk);
    if (hs_d) check("gap_after_beat", int'(rd_valid), 0);
    if (hold && rd_valid) check("hold_stable", int'({rd_last, rd_data}), int'(held));
    hs_d = rd_valid && rd_ready;
    hold = rd_valid && !rd_ready;
    held = {rd_last, rd_data};
    if (rd_valid && rd_ready) begin
      beats++;
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL extra_beat: got data %0d, expected no beat", rd_data);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", int'(rd_data), int'(e[7:0]));
        check("beat_last", int'(rd_last), int'(e[8]));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic arm_cap(input logic [3:0] p, input logic [7:0] l);
    pre = p;
    level = l;
    en = 0;
    arm = 1;
    tick;
    arm = 0;
  endtask

  task automatic feed(input logic [7:0] v, input bit gap);
    if (gap) begin
      en = 0;
      din = 8'hFF;
      tick;
    end
    en = 1;
    din = v;
    tick;
    en = 0;
  endtask

  task automatic expect_ramp(input int first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, 8'(first + 10 * i)});
  endtask

  task automatic drain(input bit rnd);
    int k = 0;
    while (busy && k < 400) begin
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick;
      k++;
    end
    rd_ready = 0;
    check("drain_done_busy", int'(busy), 0);
    check("queue_empty", exp_q.size(), 0);
    check("trig_cleared", int'(triggered), 0);
  endtask

  task automatic ramp_capture(input bit gaps);
    arm_cap(4, 55);
    for (int i = 0; i < 20; i++) begin
      feed(8'(10 * i), gaps && (i % 3 == 1));
      if (i == 5) check("no_trig_yet", int'(triggered), 0);
      if (i == 6) check("trig_at_60", int'(triggered), 1);
    end
    check("busy_before_read", int'(busy), 1);
  endtask

  initial begin
    int k, b0;
    #3;
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_rd_last", int'(rd_last), 0);
    check("rst_triggered", int'(triggered), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_rd_data", int'(rd_data), 0);
    tick;
    rst_n = 1;
    tick;
    // ramp with 4 pre-trigger samples
    ramp_capture(0);
    expect_ramp(20, 16);
    drain(0);
    // no pre-trigger history
    arm_cap(0, 55);
    for (int i = 0; i < 22; i++) feed(8'(10 * i), 0);
    check("pre0_trig", int'(triggered), 1);
    expect_ramp(60, 16);
    drain(0);
    // maximum history: trigger goes straight to readout
    arm_cap(15, 55);
    for (int i = 1; i <= 15; i++) feed(8'(i), 0);
    check("pre15_wait", int'(triggered), 0);
    feed(8'd60, 0);
    check("pre15_trig", int'(triggered), 1);
    for (int i = 1; i <= 15; i++) exp_q.push_back({1'b0, 8'(i)});
    exp_q.push_back({1'b1, 8'd60});
    drain(0);
    // en gaps during capture plus random backpressure
    ramp_capture(1);
    expect_ramp(20, 16);
    drain(1);
    // no trigger, then abort, then a normal capture
    arm_cap(2, 50);
    for (int i = 0; i < 40; i++) feed(8'd100, 0);
    check("notrig_busy", int'(busy), 1);
    check("notrig_triggered", int'(triggered), 0);
    abort = 1;
    tick;
    abort = 0;
    check("abort_busy", int'(busy), 0);
    check("abort_triggered", int'(triggered), 0);
    check("abort_rd_valid", int'(rd_valid), 0);
    ramp_capture(0);
    expect_ramp(20, 16);
    drain(0);
    // asynchronous reset while beat 7 is presented
    ramp_capture(0);
    expect_ramp(20, 16);
    b0 = beats;
    k = 0;
    rd_ready = 1;
    while (!(beats == b0 + 6 && rd_valid) && k < 200) begin
      tick;
      k++;
    end
    check("beat7_reached", beats - b0, 6);
    #2;
    rst_n = 0;
    #1;
    check("arst_rd_valid", int'(rd_valid), 0);
    check("arst_rd_data", int'(rd_data), 0);
    check("arst_rd_last", int'(rd_last), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_triggered", int'(triggered), 0);
    exp_q.delete();
    rd_ready = 0;
    tick;
    rst_n = 1;
    tick;
    check("post_rst_busy", int'(busy), 0);
    arm_cap(0, 55);
    for (int i = 0; i < 22; i++) feed(8'(10 * i), 0);
    expect_ramp(60, 16);
    drain(0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule
